// File: rtl/data_mem_responder.sv
// Data-memory target: one request at a time, response after LATENCY cycles, byte-lane steering.
// Optional DMEM_BOUNDS_CHECK_EN: addresses at or above MEM_BYTES return err instead of wrapping.
module data_mem_responder #(
    parameter int MEM_BYTES = 524288,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_mem_req_i,
    input  logic [63:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_wr_i,
    input  logic [63:0] data_mem_wr_data_i,
    output logic        data_mem_ready_o,
    output logic        data_mem_rvalid_o,
    output logic [63:0] data_mem_rd_data_o,
    output logic        data_mem_err_o
);
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int DEPTH = MEM_BYTES / 8;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] mem [DEPTH];

    logic [AW-4:0] idx;
    logic [2:0]    lane;
    logic          misaligned, oob, err_c, accept, do_write;
    logic [7:0]    size_en, lane_en;
    logic [63:0]   size_mask, wr_word, rd_shift, rd_fmt;
    logic [63:0]   rd_data_q;
    logic          err_q;

    assign idx  = data_mem_addr_i[AW-1:3];
    assign lane = data_mem_addr_i[2:0];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = |data_mem_addr_i[63:AW];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^data_mem_addr_i[63:AW];
    assign oob = 1'b0;
`endif

    always_comb begin
        misaligned = 1'b0;
        size_en    = 8'h01;
        size_mask  = 64'hFF;
        case (data_mem_byte_en_i)
            2'd1: begin misaligned = data_mem_addr_i[0];     size_en = 8'h03; size_mask = 64'hFFFF;      end
            2'd2: begin misaligned = |data_mem_addr_i[1:0];  size_en = 8'h0F; size_mask = 64'hFFFF_FFFF; end
            2'd3: begin misaligned = |data_mem_addr_i[2:0];  size_en = 8'hFF; size_mask = '1;            end
            default: ;
        endcase
    end

    // Aligned accesses never spill past lane 7, so the shifted enables fit in 8 bits.
    assign lane_en  = size_en << lane;
    assign wr_word  = data_mem_wr_data_i << {lane, 3'b000};
    assign err_c    = misaligned | oob;
    assign accept   = data_mem_req_i & data_mem_ready_o;
    assign do_write = accept & data_mem_wr_i & ~err_c;
    assign rd_shift = mem[idx] >> {lane, 3'b000};
    assign rd_fmt   = (err_c | data_mem_wr_i) ? 64'd0 : (rd_shift & size_mask);

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++)
            if (do_write && lane_en[b])
                mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rd_data_q <= 64'd0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_data_q <= rd_fmt;
                err_q     <= err_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (data_mem_req_i) begin
                if (LATENCY == 1) state_d = RESP;
                else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign data_mem_ready_o   = (state_q == IDLE);
    assign data_mem_rvalid_o  = (state_q == RESP);
    assign data_mem_rd_data_o = rd_data_q;
    assign data_mem_err_o     = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset corner cases and a
// randomized run against a byte-array reference model. Main DUT LATENCY=3, shadow DUT LATENCY=1.
module tb_data_mem_responder;
    localparam int MB  = 4096;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  sz = 2'd0;
    logic [63:0] addr = '0, wdata = '0;
    logic        ready, rvalid, err, ready1, rvalid1, err1;
    logic [63:0] rd_data, rd_data1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [MB];

    always #5 clk = ~clk;

    data_mem_responder #(.MEM_BYTES(MB), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .data_mem_req_i(req), .data_mem_addr_i(addr), .data_mem_byte_en_i(sz),
        .data_mem_wr_i(wr), .data_mem_wr_data_i(wdata),
        .data_mem_ready_o(ready), .data_mem_rvalid_o(rvalid),
        .data_mem_rd_data_o(rd_data), .data_mem_err_o(err)
    );

    data_mem_responder #(.MEM_BYTES(MB), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .data_mem_req_i(req), .data_mem_addr_i(addr), .data_mem_byte_en_i(sz),
        .data_mem_wr_i(wr), .data_mem_wr_data_i(wdata),
        .data_mem_ready_o(ready1), .data_mem_rvalid_o(rvalid1),
        .data_mem_rd_data_o(rd_data1), .data_mem_err_o(err1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference: size = 2**sz bytes, legal when address is a multiple of size.
    function automatic void model(input logic w, input logic [1:0] s, input logic [63:0] a,
                                  input logic [63:0] d, output logic [63:0] rd, output logic er);
        int nb;
        longint unsigned base;
        nb   = 1 << s;
        base = a % MB;
        er   = (a % nb) != 0;
`ifdef DMEM_BOUNDS_CHECK_EN
        if (a >= MB) er = 1'b1;
`endif
        rd = '0;
        if (!er)
            for (int b = 0; b < nb; b++)
                if (w) mem_m[int'(base) + b] = d[8*b +: 8];
                else   rd[8*b +: 8] = mem_m[int'(base) + b];
    endfunction

    // Called just after a falling edge; issues one request and checks timing and response.
    task automatic xact(input string nm, input logic w, input logic [1:0] s, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] exp_rd, input logic exp_er);
        int n;
        n = 0;
        while (!ready && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_ready"}, 64'(ready), 64'd1);
        req = 1'b1; wr = w; sz = s; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0; wr = 1'b0; addr = 64'($urandom); wdata = {$urandom, $urandom};
        n = 0;
        do begin
            @(negedge clk); n++;
            chk({nm, "_busy"}, 64'(ready), 64'd0);
            if (n == 1) begin
                chk({nm, "_l1_rvalid"}, 64'(rvalid1), 64'd1);
                chk({nm, "_l1_rd"}, rd_data1, exp_rd);
                chk({nm, "_l1_err"}, 64'(err1), 64'(exp_er));
            end
            if (n == 2) chk({nm, "_l1_idle"}, 64'({rvalid1, ready1}), 64'b01);
        end while (!rvalid && n < 20);
        chk({nm, "_latency"}, 64'(n), 64'(LAT));
        chk({nm, "_rd"}, rd_data, exp_rd);
        chk({nm, "_err"}, 64'(err), 64'(exp_er));
        @(negedge clk);
        chk({nm, "_pulse"}, 64'({rvalid, ready}), 64'b01);
        chk({nm, "_hold"}, rd_data, exp_rd);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rd;
        logic        err;
    } vec_t;

    initial begin
        vec_t        vt [15];
        logic [63:0] mrd, d, a;
        logic        mer, w;
        logic [1:0]  s;
        int          rv_seen;

        vt[0]  = '{1'b1, 2'd3, 64'h100, 64'h1122334455667788, 64'h0, 1'b0};
        vt[1]  = '{1'b0, 2'd0, 64'h103, 64'h0, 64'h55, 1'b0};
        vt[2]  = '{1'b0, 2'd1, 64'h106, 64'h0, 64'h1122, 1'b0};
        vt[3]  = '{1'b1, 2'd0, 64'h101, 64'hFFFFFFFFFFFFFFAB, 64'h0, 1'b0};
        vt[4]  = '{1'b0, 2'd3, 64'h100, 64'h0, 64'h112233445566AB88, 1'b0};
        vt[5]  = '{1'b1, 2'd2, 64'h102, 64'hCAFEBABE, 64'h0, 1'b1};
        vt[6]  = '{1'b0, 2'd3, 64'h100, 64'h0, 64'h112233445566AB88, 1'b0};
        vt[7]  = '{1'b0, 2'd2, 64'h104, 64'h0, 64'h11223344, 1'b0};
        vt[8]  = '{1'b0, 2'd1, 64'h101, 64'h0, 64'h0, 1'b1};
        vt[9]  = '{1'b1, 2'd3, 64'h108, 64'h0, 64'h0, 1'b0};
        vt[10] = '{1'b1, 2'd1, 64'h10A, 64'hFFFFFFFFFFFFBEEF, 64'h0, 1'b0};
        vt[11] = '{1'b0, 2'd3, 64'h108, 64'h0, 64'h00000000BEEF0000, 1'b0};
        vt[12] = '{1'b0, 2'd0, 64'h10B, 64'h0, 64'hBE, 1'b0};
        vt[13] = '{1'b0, 2'd3, 64'h10C, 64'h0, 64'h0, 1'b1};
        vt[14] = '{1'b0, 2'd0, 64'h107, 64'h0, 64'h11, 1'b0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rd", rd_data, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_l1", 64'({ready1, rvalid1, err1}), 64'b100);

        // Fill every word so the model and the array agree before any read.
        for (int i = 0; i < MB / 8; i++) begin
            d = {$urandom, $urandom};
            model(1'b1, 2'd3, 64'(i * 8), d, mrd, mer);
            xact("fill", 1'b1, 2'd3, 64'(i * 8), d, 64'd0, 1'b0);
        end

        foreach (vt[i]) begin
            model(vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wdata, mrd, mer);
            xact($sformatf("vec%0d", i), vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].err);
        end

        // Reset while the write is still in WAIT: response dropped, write kept.
        model(1'b1, 2'd1, 64'h200, 64'hDEAD, mrd, mer);
        req = 1'b1; wr = 1'b1; sz = 2'd1; addr = 64'h200; wdata = 64'hDEAD;
        @(posedge clk);
        #1 req = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("rstw_in_wait", 64'(ready), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rvalid) rv_seen++;
            if (k == 0) chk("rstw_ready", 64'(ready), 64'd1);
        end
        chk("rstw_no_rvalid", 64'(rv_seen), 64'd0);
        xact("rstw_read", 1'b0, 2'd1, 64'h200, 64'h0, 64'hDEAD, 1'b0);

        // Out-of-range read: wraps to 0x8 or errors, depending on the build.
        model(1'b0, 2'd3, 64'(MB + 8), 64'h0, mrd, mer);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("oob_model", {63'd0, mer}, 64'd1);
`endif
        xact("oob", 1'b0, 2'd3, 64'(MB + 8), 64'h0, mrd, mer);

        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            a = 64'($urandom_range(0, MB - 1));
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << s) - 1);
            if ($urandom_range(0, 9) == 0) a = a | (64'd1 << $urandom_range($clog2(MB), 63));
            d = {$urandom, $urandom};
            model(w, s, a, d, mrd, mer);
            xact("rand", w, s, a, d, mrd, mer);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
